dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port dmem between the processor and an auxiliary requester (loader/debug). It sits between the requesters and the dmem syncram in the skeleton, muxing address, write data and write enable onto the one port. It returns read data with a one-cycle-latency valid strobe. Fixed priority with an anti-starvation counter, or optionally round-robin, decides which requester owns each cycle.

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose: shares the single-port dmem between requester 0 (processor) and requester 1 (loader/debug).
// Latency: grant is combinational (0 cycles); read data valid one cycle after the grant.
// Backpressure: a losing requester holds req and payload until its gnt; there is no queueing.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration. When undefined, req0 has
// fixed priority and an 8-bit starvation counter forces req1 through after MAX_WAIT denials.
//
// Ports:
//   clock, reset                 single clock, asynchronous active-high reset
//   req*/we*/addr*/wdata*        per-requester access request and payload
//   gnt0/gnt1                    combinational grant, access issued this cycle
//   rvalid0/rvalid1, rdata       registered read-valid strobes, rdata mirrors q_dmem
//   address_dmem/data/wren       muxed dmem port, q_dmem is the dmem read data
//   conflict_cnt                 saturating count of cycles with both requests high
module dmem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem,
    output logic [15:0]       conflict_cnt
);

    // pick1: requester 1 owns the port this cycle if it is requesting.
    logic pick1;

`ifdef DMEM_ARB_RR_EN
    // ptr names the preferred requester on a contested cycle.
    logic ptr;

    always_comb begin
        pick1 = req1;
        if (req0 && req1) begin
            pick1 = ptr;
        end
    end

    // After any grant, preference passes to the requester that did not win.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end
`else
    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    logic [7:0] wait1;

    // req1 wins when uncontested, or when it has been denied MAX_WAIT cycles in a row.
    always_comb begin
        pick1 = req1 && (!req0 || (wait1 == MAX_WAIT_L));
    end

    // wait1 never passes MAX_WAIT: reaching it forces gnt1, which clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait1 <= 8'd0;
        end else if (!req1 || gnt1) begin
            wait1 <= 8'd0;
        end else begin
            wait1 <= wait1 + 8'd1;
        end
    end
`endif

    // Grants are suppressed while reset is high so nothing reaches dmem.
    assign gnt1 = !reset && pick1;
    assign gnt0 = !reset && req0 && !pick1;

    // Requester 0's payload is the idle default on the dmem port.
    assign address_dmem = gnt1 ? addr1  : addr0;
    assign data         = gnt1 ? wdata1 : wdata0;
    assign wren         = (gnt0 && we0) || (gnt1 && we1);
    assign rdata        = q_dmem;

    // dmem returns read data one cycle after sampling, so the strobe is the delayed read grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_cnt <= 16'd0;
        end else if (req0 && req1 && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1, wren;
    logic [DATA_W-1:0] rdata, data, q_dmem;
    logic [ADDR_W-1:0] address_dmem;
    logic [15:0]       conflict_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem),
        .conflict_cnt(conflict_cnt)
    );

    // Synchronous single-port RAM standing in for the dmem syncram (old data on read).
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clock) begin
        if (wren) ram[address_dmem] <= data;
        q_dmem <= ram[address_dmem];
    end

    // Reference model state.
    logic [DATA_W-1:0] m_mem [0:(1<<ADDR_W)-1];
    int          m_wait, m_conf;
    bit          m_ptr, m_rv0, m_rv1;
    logic [31:0] m_rd;
    bit          do_checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_wait = 0; m_conf = 0; m_ptr = 0; m_rv0 = 0; m_rv1 = 0;
    endtask

    // One clock cycle: predict and check at the falling edge, advance the model at the rising edge.
    task automatic step(output bit og0, output bit og1, output bit orv0, output bit orv1,
                        output logic [31:0] ord);
        bit eg0, eg1, ewe;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        @(negedge clock);
        eg0 = 0; eg1 = 0;
        if (!reset) begin
`ifdef DMEM_ARB_RR_EN
            if (req0 && req1) begin
                eg0 = (m_ptr == 0); eg1 = !eg0;
            end else begin
                eg0 = req0; eg1 = req1;
            end
`else
            eg1 = req1 && (!req0 || m_wait >= MAX_WAIT);
            eg0 = req0 && !eg1;
`endif
        end
        ewe = (eg0 && we0) || (eg1 && we1);
        ea  = eg1 ? addr1 : addr0;
        ed  = eg1 ? wdata1 : wdata0;
        og0 = gnt0; og1 = gnt1; orv0 = rvalid0; orv1 = rvalid1; ord = rdata;
        if (do_checks) begin
            check("gnt0", 32'(gnt0), 32'(eg0));
            check("gnt1", 32'(gnt1), 32'(eg1));
            check("wren", 32'(wren), 32'(ewe));
            if (eg0 || eg1) begin
                check("address_dmem", 32'(address_dmem), 32'(ea));
                if (ewe) check("data", data, ed);
            end
            check("rvalid0", 32'(rvalid0), 32'(m_rv0));
            check("rvalid1", 32'(rvalid1), 32'(m_rv1));
            if (m_rv0 || m_rv1) check("rdata", rdata, m_rd);
            check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        end
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            m_rv0 = eg0 && !we0;
            m_rv1 = eg1 && !we1;
            if ((eg0 || eg1) && !ewe) m_rd = m_mem[ea];
            if (ewe) m_mem[ea] = ed;
            if (req0 && req1 && m_conf < 65535) m_conf++;
            m_wait = (!req1 || eg1) ? 0 : m_wait + 1;
            if (eg0) m_ptr = 1;
            else if (eg1) m_ptr = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    bit g0, g1, rv0, rv1;
    logic [31:0] rd;
    int n_g0;
    bit p0, p1;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]   = 32'hA500_0000 | 32'(i);
            m_mem[i] = 32'hA500_0000 | 32'(i);
        end
        ram[12'h010]   = 32'hDEADBEEF;
        m_mem[12'h010] = 32'hDEADBEEF;
        do_checks = 1;
        idle_inputs();
        model_clear();
        reset = 1;
        #1;
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_conflict", 32'(conflict_cnt), 32'd0);
        step(g0, g1, rv0, rv1, rd);
        step(g0, g1, rv0, rv1, rd);
        reset = 0;

        // Uncontested read by requester 1.
        req1 = 1; we1 = 0; addr1 = 12'h010;
        step(g0, g1, rv0, rv1, rd);
        check("t1_gnt1_same_cycle", 32'(g1), 32'd1);
        idle_inputs();
        step(g0, g1, rv0, rv1, rd);
        check("t1_rvalid1", 32'(rv1), 32'd1);
        check("t1_rdata", rd, 32'hDEADBEEF);
        check("t1_rvalid0", 32'(rv0), 32'd0);

        // Write then read back by requester 0.
        req0 = 1; we0 = 1; addr0 = 12'h020; wdata0 = 32'h12345678;
        step(g0, g1, rv0, rv1, rd);
        check("t2_gnt0_wr", 32'(g0), 32'd1);
        we0 = 0; wdata0 = '0;
        step(g0, g1, rv0, rv1, rd);
        check("t2_gnt0_rd", 32'(g0), 32'd1);
        check("t2_no_rvalid_after_wr", 32'(rv0), 32'd0);
        idle_inputs();
        step(g0, g1, rv0, rv1, rd);
        check("t2_rvalid0", 32'(rv0), 32'd1);
        check("t2_rdata", rd, 32'h12345678);

        // Write by 0 followed immediately by read by 1 at the same address.
        req0 = 1; we0 = 1; addr0 = 12'h0FF; wdata0 = 32'hC0FFEE01;
        step(g0, g1, rv0, rv1, rd);
        idle_inputs();
        req1 = 1; we1 = 0; addr1 = 12'h0FF;
        step(g0, g1, rv0, rv1, rd);
        check("t6_gnt1", 32'(g1), 32'd1);
        idle_inputs();
        step(g0, g1, rv0, rv1, rd);
        check("t6_rvalid1", 32'(rv1), 32'd1);
        check("t6_rdata", rd, 32'hC0FFEE01);

        // Continuous contention from a fresh reset.
        reset = 1; model_clear();
        step(g0, g1, rv0, rv1, rd);
        reset = 0;
        req0 = 1; addr0 = 12'h001; req1 = 1; addr1 = 12'h002;
        n_g0 = 0;
`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            step(g0, g1, rv0, rv1, rd);
            check("t3_rr_gnt0", 32'(g0), 32'((i % 2) == 0));
        end
`else
        for (int i = 0; i < MAX_WAIT; i++) begin
            step(g0, g1, rv0, rv1, rd);
            n_g0 += int'(g0);
        end
        check("t3_gnt0_run", 32'(n_g0), 32'(MAX_WAIT));
        step(g0, g1, rv0, rv1, rd);
        check("t3_forced_gnt1", 32'(g1), 32'd1);
        check("t3_conflict_cnt", 32'(conflict_cnt), 32'(MAX_WAIT + 1));
`endif
        idle_inputs();
        step(g0, g1, rv0, rv1, rd);

        // Reset arriving the cycle after a granted read.
        req0 = 1; we0 = 0; addr0 = 12'h005;
        step(g0, g1, rv0, rv1, rd);
        check("t4_gnt0", 32'(g0), 32'd1);
        reset = 1; model_clear();
        #1;
        check("t4_rvalid0_async", 32'(rvalid0), 32'd0);
        req1 = 1; we1 = 1; addr1 = 12'h006;
        for (int i = 0; i < 3; i++) begin
            step(g0, g1, rv0, rv1, rd);
            check("t4_no_gnt_in_reset", 32'(g0 | g1), 32'd0);
        end
        reset = 0;
        idle_inputs();
        step(g0, g1, rv0, rv1, rd);
        check("t4_rvalid0_after", 32'(rv0), 32'd0);
        check("t4_conflict_zero", 32'(conflict_cnt), 32'd0);

        // Saturation of the conflict counter.
        do_checks = 0;
        req0 = 1; addr0 = 12'h030; req1 = 1; addr1 = 12'h031;
        for (int i = 0; i < 70000; i++) step(g0, g1, rv0, rv1, rd);
        check("t5_saturated", 32'(conflict_cnt), 32'hFFFF);
        step(g0, g1, rv0, rv1, rd);
        check("t5_holds", 32'(conflict_cnt), 32'hFFFF);
        do_checks = 1;
        idle_inputs();
        step(g0, g1, rv0, rv1, rd);

        // Randomised traffic from both requesters against the model.
        reset = 1; model_clear();
        step(g0, g1, rv0, rv1, rd);
        reset = 0;
        p0 = 0; p1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; we0 = 1'($urandom); addr0 = 12'($urandom_range(0, 15)); wdata0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; we1 = 1'($urandom); addr1 = 12'($urandom_range(0, 15)); wdata1 = $urandom;
            end else if (p1 && $urandom_range(0, 15) == 0) begin
                p1 = 0;
            end
            req0 = p0; req1 = p1;
            step(g0, g1, rv0, rv1, rd);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end
        idle_inputs();
        step(g0, g1, rv0, rv1, rd);
        step(g0, g1, rv0, rv1, rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
